// File: rtl/mem_except_pkg.sv
// Shared constants for MEM-stage exception detection and the CP0 register file:
// exception codes, CP0 register addresses, raw flag bit positions and FSM states.
package mem_except_pkg;

  localparam logic [31:0] EXC_NONE      = 32'h0000_0000;
  localparam logic [31:0] EXC_INT       = 32'h0000_0001;
  localparam logic [31:0] EXC_ADEL_LD   = 32'h0000_0004;
  localparam logic [31:0] EXC_ADES_ST   = 32'h0000_0005;
  localparam logic [31:0] EXC_SYSCALL   = 32'h0000_0008;
  localparam logic [31:0] EXC_BREAK     = 32'h0000_0009;
  localparam logic [31:0] EXC_RI        = 32'h0000_000a;
  localparam logic [31:0] EXC_OVERFLOW  = 32'h0000_000c;
  localparam logic [31:0] EXC_TRAP      = 32'h0000_000d;
  localparam logic [31:0] EXC_ERET      = 32'h0000_000e;
  localparam logic [31:0] EXC_ADEL_IF   = 32'h0000_000f;

  localparam logic [4:0] CP0_REG_STATUS = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE  = 5'd13;

  localparam int FLAG_ADEL_IF = 0;
  localparam int FLAG_RI      = 1;
  localparam int FLAG_SYSCALL = 2;
  localparam int FLAG_BREAK   = 3;
  localparam int FLAG_TRAP    = 4;
  localparam int FLAG_OVERFLOW = 5;
  localparam int FLAG_ERET    = 6;

  localparam int HOLD_CNT_W = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/mem_align_check.sv
// Data access alignment check: flags half accesses on odd addresses and word
// accesses (size 2 or 3) whose low two address bits are not zero.
module mem_align_check (
  input  logic [1:0] size_i,
  input  logic [1:0] addr_lo_i,
  output logic       misaligned_o
);

  always_comb begin
    misaligned_o = 1'b0;
    case (size_i)
      2'd0:    misaligned_o = 1'b0;
      2'd1:    misaligned_o = addr_lo_i[0];
      default: misaligned_o = (addr_lo_i != 2'b00);
    endcase
  end

endmodule

// File: rtl/mem_except.sv
// MEM-stage exception prioritiser with CP0 write bypass and a post-flush hold
// window during which no further exception is reported.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | exceptions may be reported for a valid, unstalled instruction
//   ST_HOLD | reporting blocked for FLUSH_HOLD cycles after a flush
module mem_except
  import mem_except_pkg::*;
#(
  parameter int FLUSH_HOLD = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic        stall_i,
  input  logic [31:0] pc_i,
  input  logic        is_in_delayslot_i,
  input  logic [6:0]  excflags_i,
  input  logic        mem_load_i,
  input  logic        mem_store_i,
  input  logic [1:0]  mem_size_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_data_i,
  output logic [31:0] except_type_o,
  output logic [31:0] pc_o,
  output logic        is_in_delayslot_o,
  output logic [31:0] mem_addr_o,
  output logic        flush_o,
  output logic        mem_kill_o
);

  state_e                state_q, state_d;
  logic [HOLD_CNT_W-1:0] cnt_q, cnt_d;

  logic        misaligned;
  logic [31:0] status_eff;
  logic [31:0] cause_eff;
  logic        int_pending;
  logic [31:0] raw_code;

  mem_align_check u_align (
    .size_i       (mem_size_i),
    .addr_lo_i    (mem_addr_i[1:0]),
    .misaligned_o (misaligned)
  );

  // Only the software-writable Cause fields (IP1:IP0, IV/WP) come from WB.
  always_comb begin
    status_eff = cp0_status_i;
    cause_eff  = cp0_cause_i;
    if (wb_cp0_we_i && wb_cp0_waddr_i == CP0_REG_STATUS) begin
      status_eff = wb_cp0_data_i;
    end
    if (wb_cp0_we_i && wb_cp0_waddr_i == CP0_REG_CAUSE) begin
      cause_eff[9:8]   = wb_cp0_data_i[9:8];
      cause_eff[23:22] = wb_cp0_data_i[23:22];
    end
    int_pending = (|(cause_eff[15:8] & status_eff[15:8])) && status_eff[0] && !status_eff[1];
  end

  always_comb begin
    raw_code = EXC_NONE;
    if (!valid_i)                                 raw_code = EXC_NONE;
    else if (int_pending)                         raw_code = EXC_INT;
    else if (excflags_i[FLAG_ADEL_IF])            raw_code = EXC_ADEL_IF;
    else if (excflags_i[FLAG_RI])                 raw_code = EXC_RI;
    else if (excflags_i[FLAG_SYSCALL])            raw_code = EXC_SYSCALL;
    else if (excflags_i[FLAG_BREAK])              raw_code = EXC_BREAK;
    else if (excflags_i[FLAG_TRAP])               raw_code = EXC_TRAP;
    else if (excflags_i[FLAG_OVERFLOW])           raw_code = EXC_OVERFLOW;
    else if (mem_load_i && misaligned)            raw_code = EXC_ADEL_LD;
    else if (mem_store_i && misaligned)           raw_code = EXC_ADES_ST;
    else if (excflags_i[FLAG_ERET])               raw_code = EXC_ERET;
  end

  always_comb begin
    except_type_o     = EXC_NONE;
    mem_kill_o        = 1'b0;
    pc_o              = '0;
    is_in_delayslot_o = 1'b0;
    mem_addr_o        = '0;
    if (!rst) begin
      if (state_q == ST_IDLE && !stall_i) begin
        except_type_o = raw_code;
      end
      mem_kill_o        = (raw_code != EXC_NONE) || (state_q == ST_HOLD);
      pc_o              = pc_i;
      is_in_delayslot_o = is_in_delayslot_i;
      mem_addr_o        = mem_addr_i;
    end
    flush_o = (except_type_o != EXC_NONE);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (except_type_o != EXC_NONE) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_CNT_W'(FLUSH_HOLD - 1);
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: doc/mem_except.md
MEM_EXCEPT -- requirements
Module: mem_except

Interface
REQ-001 Parameter FLUSH_HOLD, default 2, cycles (1..3) exception reporting stays blocked after a flush.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  reset; synchronous, active-high.
REQ-004 valid_i  in  1  MEM stage holds a real instruction; 0 means bubble.
REQ-005 stall_i  in  1  MEM stage stalled this cycle.
REQ-006 pc_i  in  32  PC of the MEM-stage instruction.
REQ-007 is_in_delayslot_i  in  1  MEM-stage instruction is in a delay slot.
REQ-008 excflags_i  in  7  raw flags: [0] fetch AdEL, [1] reserved instruction, [2] syscall, [3] break, [4] trap, [5] overflow, [6] eret.
REQ-009 mem_load_i / mem_store_i  in  1 each  instruction is a load / store.
REQ-010 mem_size_i  in  2  0 byte, 1 half, 2 word; 3 treated as word.
REQ-011 mem_addr_i  in  32  effective data address.
REQ-012 cp0_status_i / cp0_cause_i  in  32 each  current CP0 Status / Cause.
REQ-013 wb_cp0_we_i, wb_cp0_waddr_i (5), wb_cp0_data_i (32)  in  CP0 write retiring in WB this cycle.
REQ-014 except_type_o  out  32  exception code consumed by CP0.
REQ-015 pc_o, is_in_delayslot_o (1), mem_addr_o (32)  out  pass-through copies of pc_i, is_in_delayslot_i, mem_addr_i.
REQ-016 flush_o  out  1  pipeline flush request.
REQ-017 mem_kill_o  out  1  suppress data-memory access of the MEM instruction.

Function
REQ-018 Bypass: effective Status/Cause = wb_cp0_data_i when wb_cp0_we_i and waddr is 12 / 13; Cause bypass replaces only bits [9:8], [23:22]; otherwise cp0_*_i.
REQ-019 Interrupt pending = |(eff Cause[15:8] & eff Status[15:8]) && Status[0] && !Status[1].
REQ-020 Misaligned = (size 1 && addr[0]) || (size>=2 && addr[1:0]!=0).
REQ-021 Codes, highest priority first: interrupt 0x1, fetch AdEL 0xf, RI 0xa, syscall 0x8, break 0x9, trap 0xd, overflow 0xc, load misaligned 0x4, store misaligned 0x5, eret 0xe; none 0x0.
REQ-022 except_type_o is combinational, same cycle as inputs, nonzero only when state is IDLE, valid_i=1, stall_i=0.
REQ-023 flush_o = (except_type_o != 0), same cycle.
REQ-024 mem_kill_o = 1 whenever any code would be selected (ignoring stall), or state is HOLD.
REQ-025 FSM IDLE: on except_type_o != 0 go HOLD, load counter with FLUSH_HOLD-1; else stay.
REQ-026 FSM HOLD: except_type_o=0, flush_o=0; counter decrements each cycle; at 0 return to IDLE regardless of stall_i.
REQ-027 Interrupt raised while blocked (bubble, stall, HOLD) is not lost: taken on the first qualifying cycle where REQ-019 still holds.
REQ-028 Simultaneous exception and wb CP0 write: bypassed values decide interrupt pending.

Reset
REQ-029 During rst: state IDLE, counter 0, except_type_o=0, flush_o=0, mem_kill_o=0; pass-through outputs 0.
REQ-030 rst asserted mid-HOLD returns to IDLE on the next edge; no flush emitted in that cycle.

Structure
REQ-031 Exception code constants, CP0 register addresses and the flag-bit index constants belong in the shared package/define header used by the CP0 register file.
REQ-032 One sub-module natural: mem_align_check (size/addr -> misaligned), combinational.

Verification
REQ-033 Status=0x0000_0401, Cause[10]=1, valid, no stall -> except_type_o=0x1, flush_o=1, then 2 cycles of 0 (FLUSH_HOLD=2).
REQ-034 Load, size 2, addr 0x8000_0002 -> 0x4, mem_kill_o=1, mem_addr_o=0x8000_0002; size 0 same addr -> 0x0.
REQ-035 excflags_i=0x22 (RI+overflow) -> 0xa; excflags_i=0x40 -> 0xe, flush_o=1.
REQ-036 Syscall with stall_i=1 for 3 cycles -> 0x0 throughout, 0x8 on first unstalled cycle.
REQ-037 Status reg 0x0 but WB writes Status=0x0000_0401 same cycle, Cause[10]=1 -> 0x1.
REQ-038 rst during HOLD -> next cycle IDLE; new syscall reported immediately after rst deasserts.
